// File: rtl/exu_mul_pipe_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exu_mul_pipe_gen_pkg                                         |
// | Desc     : shared types and constants for the generic EXU multiplier    |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
package exu_mul_pipe_gen_pkg;

  localparam int XLEN_DEF = 32;
  localparam int PROD_W   = 2 * XLEN_DEF + 2;

  // Control bundle that travels with an op through stage 1
  typedef struct packed {
    logic valid;
    logic rs1_sign;
    logic rs2_sign;
    logic low;
    logic rs1_byp;
    logic rs2_byp;
  } mul_pkt_gen_t;

  // Width of the full signed (XLEN+1)x(XLEN+1) product
  function automatic int prod_w(input int xlen);
    return 2 * xlen + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exu_mul_pipe_gen_dly_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exu_mul_dly_pipe                                             |
// | Desc     : valid+data delay line with freeze (hold) and flush (kill)    |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module exu_mul_dly_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         freeze,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         busy
);

  logic         r_vld [DEPTH];
  logic [W-1:0] r_dat [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic         w_vin;
    logic [W-1:0] w_din;

    if (i == 0) begin : g_head
      assign w_vin = in_valid;
      assign w_din = in_data;
    end else begin : g_tail
      assign w_vin = r_vld[i-1];
      assign w_din = r_dat[i-1];
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        r_vld[i] <= 1'b0;
      end else if (flush) begin
        r_vld[i] <= 1'b0;
      end else if (!freeze) begin
        r_vld[i] <= w_vin;
      end
    end

    // Data only moves with a live op, so idle stages stay quiet
    always_ff @(posedge clk) begin
      if (w_vin && !freeze) begin
        r_dat[i] <= w_din;
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_data  = r_dat[DEPTH-1];

  always_comb begin
    busy = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      busy = busy | r_vld[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/exu_mul_pipe_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exu_mul_pipe_gen                                             |
// | Desc     : parametrised pipelined RISC-V MUL/MULH/MULHSU/MULHU unit     |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module exu_mul_pipe_gen
  import exu_mul_pipe_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            freeze,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            rs1_sign,
  input  logic            rs2_sign,
  input  logic            low,
  input  logic            rs1_byp,
  input  logic            rs2_byp,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag,
  input  logic [XLEN-1:0] lsu_result,
  output logic            out_valid,
  output logic [XLEN-1:0] out,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int c_PROD_W = prod_w(XLEN);
  localparam int c_DW     = 2 * XLEN + 1 + TAGW;

  if (STAGES < 2) begin : g_bad_stages
    $error("exu_mul_pipe_gen: STAGES must be at least 2");
  end

  // ---------------- stage 1: capture ----------------
  mul_pkt_gen_t    r_s1_pkt;
  logic [XLEN-1:0] r_s1_a;
  logic [XLEN-1:0] r_s1_b;
  logic [TAGW-1:0] r_s1_tag;
  logic            w_s1_en;

  assign w_s1_en = in_valid & ~freeze;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s1_pkt <= '0;
    end else begin
      if (flush) begin
        r_s1_pkt.valid <= 1'b0;
      end else if (!freeze) begin
        r_s1_pkt.valid <= in_valid;
      end
      if (w_s1_en) begin
        r_s1_pkt.rs1_sign <= rs1_sign;
        r_s1_pkt.rs2_sign <= rs2_sign;
        r_s1_pkt.low      <= low;
        r_s1_pkt.rs1_byp  <= rs1_byp;
        r_s1_pkt.rs2_byp  <= rs2_byp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_en) begin
      r_s1_a   <= a;
      r_s1_b   <= b;
      r_s1_tag <= tag;
    end
  end

  // Load data arrives a cycle after issue, so the bypass mux sits after capture
  logic [XLEN-1:0] w_s1_opa;
  logic [XLEN-1:0] w_s1_opb;
  logic [XLEN:0]   w_s1_xa;
  logic [XLEN:0]   w_s1_xb;

  assign w_s1_opa = r_s1_pkt.rs1_byp ? lsu_result : r_s1_a;
  assign w_s1_opb = r_s1_pkt.rs2_byp ? lsu_result : r_s1_b;
  assign w_s1_xa  = {r_s1_pkt.rs1_sign & w_s1_opa[XLEN-1], w_s1_opa};
  assign w_s1_xb  = {r_s1_pkt.rs2_sign & w_s1_opb[XLEN-1], w_s1_opb};

  // ---------------- stage 2: extended operands ----------------
  logic            w_mx_vld;
  logic [XLEN:0]   w_mx_xa;
  logic [XLEN:0]   w_mx_xb;
  logic            w_mx_low;
  logic [TAGW-1:0] w_mx_tag;
  logic            w_s2_busy;

  if (STAGES >= 3) begin : g_s2
    logic            r_vld;
    logic [XLEN:0]   r_xa;
    logic [XLEN:0]   r_xb;
    logic            r_low;
    logic [TAGW-1:0] r_tag;

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        r_vld <= 1'b0;
      end else if (flush) begin
        r_vld <= 1'b0;
      end else if (!freeze) begin
        r_vld <= r_s1_pkt.valid;
      end
    end

    always_ff @(posedge clk) begin
      if (r_s1_pkt.valid && !freeze) begin
        r_xa  <= w_s1_xa;
        r_xb  <= w_s1_xb;
        r_low <= r_s1_pkt.low;
        r_tag <= r_s1_tag;
      end
    end

    assign w_mx_vld  = r_vld;
    assign w_mx_xa   = r_xa;
    assign w_mx_xb   = r_xb;
    assign w_mx_low  = r_low;
    assign w_mx_tag  = r_tag;
    assign w_s2_busy = r_vld;
  end else begin : g_no_s2
    assign w_mx_vld  = r_s1_pkt.valid;
    assign w_mx_xa   = w_s1_xa;
    assign w_mx_xb   = w_s1_xb;
    assign w_mx_low  = r_s1_pkt.low;
    assign w_mx_tag  = r_s1_tag;
    assign w_s2_busy = 1'b0;
  end

  // Signed multiply of the sign-corrected operands covers all four flavours
  logic signed [c_PROD_W-1:0] w_ext_a;
  logic signed [c_PROD_W-1:0] w_ext_b;
  logic signed [c_PROD_W-1:0] w_prod_full;
  logic [2*XLEN-1:0]          w_prod;
  logic [1:0]                 w_unused_prod_hi;

  assign w_ext_a          = {{(XLEN+1){w_mx_xa[XLEN]}}, w_mx_xa};
  assign w_ext_b          = {{(XLEN+1){w_mx_xb[XLEN]}}, w_mx_xb};
  assign w_prod_full      = w_ext_a * w_ext_b;
  assign w_prod           = w_prod_full[2*XLEN-1:0];
  assign w_unused_prod_hi = w_prod_full[c_PROD_W-1 -: 2];

  // ---------------- stages 3..STAGES-1: delay ----------------
  logic [c_DW-1:0] w_dl_in;
  logic [c_DW-1:0] w_dl_data;
  logic            w_dl_vld;
  logic            w_dl_busy;

  assign w_dl_in = {w_prod, w_mx_low, w_mx_tag};

  if (STAGES >= 4) begin : g_dly
    exu_mul_dly_pipe #(
      .W     (c_DW),
      .DEPTH (STAGES - 3)
    ) u_dly (
      .clk       (clk),
      .rst_l     (rst_l),
      .freeze    (freeze),
      .flush     (flush),
      .in_valid  (w_mx_vld),
      .in_data   (w_dl_in),
      .out_valid (w_dl_vld),
      .out_data  (w_dl_data),
      .busy      (w_dl_busy)
    );
  end else begin : g_no_dly
    assign w_dl_vld  = w_mx_vld;
    assign w_dl_data = w_dl_in;
    assign w_dl_busy = 1'b0;
  end

  // ---------------- output register ----------------
  logic [2*XLEN-1:0] w_dl_prod;
  logic              w_dl_low;
  logic [TAGW-1:0]   w_dl_tag;
  logic [XLEN-1:0]   w_res;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out;
  logic [TAGW-1:0]   r_out_tag;

  assign w_dl_prod = w_dl_data[c_DW-1 -: 2*XLEN];
  assign w_dl_low  = w_dl_data[TAGW];
  assign w_dl_tag  = w_dl_data[TAGW-1:0];
  assign w_res     = w_dl_low ? w_dl_prod[XLEN-1:0] : w_dl_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_tag   <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (!freeze) begin
        r_out_valid <= w_dl_vld;
      end
      // A killed op must not disturb the held result
      if (w_dl_vld && !freeze && !flush) begin
        r_out     <= w_res;
        r_out_tag <= w_dl_tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_tag   = r_out_tag;
  assign busy      = r_s1_pkt.valid | w_s2_busy | w_dl_busy | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_exu_mul_pipe_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_exu_mul_pipe_gen                                          |
// | Desc     : directed bench for exu_mul_pipe_gen at STAGES = 2, 3 and 5   |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module tb_exu_mul_pipe_gen;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        freeze, flush, in_valid;
  logic        rs1_sign, rs2_sign, low, rs1_byp, rs2_byp;
  logic [31:0] a, b, lsu_result;
  logic [4:0]  tag;

  logic        ov2, ov3, ov5, b2, b3, b5;
  logic [31:0] o2, o3, o5;
  logic [4:0]  t2, t3, t5;

  always #5 clk = ~clk;

  exu_mul_pipe_gen #(.XLEN(32), .STAGES(3), .TAGW(5)) u_dut3 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .rs1_byp(rs1_byp),
    .rs2_byp(rs2_byp), .a(a), .b(b), .tag(tag), .lsu_result(lsu_result),
    .out_valid(ov3), .out(o3), .out_tag(t3), .busy(b3));

  exu_mul_pipe_gen #(.XLEN(32), .STAGES(2), .TAGW(5)) u_dut2 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .rs1_byp(rs1_byp),
    .rs2_byp(rs2_byp), .a(a), .b(b), .tag(tag), .lsu_result(lsu_result),
    .out_valid(ov2), .out(o2), .out_tag(t2), .busy(b2));

  exu_mul_pipe_gen #(.XLEN(32), .STAGES(5), .TAGW(5)) u_dut5 (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .low(low), .rs1_byp(rs1_byp),
    .rs2_byp(rs2_byp), .a(a), .b(b), .tag(tag), .lsu_result(lsu_result),
    .out_valid(ov5), .out(o5), .out_tag(t5), .busy(b5));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s1;
    logic        s2;
    logic        lo;
    logic [31:0] req;
    string       nm;
  } vec_t;

  vec_t        vecs [12];
  logic [4:0]  tg;
  logic [31:0] bb_req [3];
  int          fz_iv  [9];
  int          fz_frz [9];
  int          fz_op  [9];
  int          fz_ov  [9];
  logic [31:0] fz_out [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic s1, input logic s2, input logic lo, input logic [4:0] t);
    in_valid = v; a = ia; b = ib; rs1_sign = s1; rs2_sign = s2; low = lo; tag = t;
    rs1_byp = 1'b0; rs2_byp = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; freeze = 1'b0; flush = 1'b0; rs1_byp = 1'b0; rs2_byp = 1'b0;
  endtask

  // k counts edges since issue (issue edge is k=1); result due when k == n
  task automatic chk_lat(input string nm, input int n, input int k, input logic v,
                         input logic [31:0] o, input logic [4:0] t,
                         input logic [31:0] req, input logic [4:0] rt);
    chk($sformatf("%s_s%0d_valid_k%0d", nm, n, k), {63'd0, v}, {63'd0, k == n});
    if (k == n) begin
      chk($sformatf("%s_s%0d_out", nm, n), {32'd0, o}, {32'd0, req});
      chk($sformatf("%s_s%0d_tag", nm, n), {59'd0, t}, {59'd0, rt});
    end
  endtask

  task automatic byp_test(input string nm, input logic by1, input logic by2,
                          input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ld, input logic [31:0] req);
    drive(1'b1, ia, ib, 1'b0, 1'b0, 1'b1, 5'd9);
    rs1_byp = by1; rs2_byp = by2; lsu_result = 32'd99;
    tick();                      // accepted; stage 1 is this cycle
    idle(); lsu_result = ld;
    tick();
    lsu_result = 32'd0;
    chk({nm, "_s2_out"}, {32'd0, o2}, {32'd0, req});
    tick();
    chk({nm, "_s3_valid"}, {63'd0, ov3}, 64'd1);
    chk({nm, "_s3_out"}, {32'd0, o3}, {32'd0, req});
    chk({nm, "_s3_tag"}, {59'd0, t3}, 64'd9);
    tick(); tick();
    chk({nm, "_s5_out"}, {32'd0, o5}, {32'd0, req});
    tick();
  endtask

  initial begin
    vecs[0]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h40000000, "mulh_min_min"};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, "mulhsu_m1"};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, "mulhu_max"};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000001, "mul_m1"};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000000, "mulh_m1"};
    vecs[5]  = '{32'h12345678, 32'h00000010, 1'b0, 1'b0, 1'b1, 32'h23456780, "mul_small"};
    vecs[6]  = '{32'h80000000, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'h00000001, "mulhu_two"};
    vecs[7]  = '{32'h80000000, 32'h00000002, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, "mulh_neg"};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h80000000, "mulhsu_min"};
    vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 32'h3FFFFFFF, "mulh_max"};
    vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h80000000, "mul_lowmix"};
    vecs[11] = '{32'h00000002, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001, "mulhsu_posbig"};

    bb_req = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    // freeze scenario per edge: inputs, then expected state after that edge
    fz_iv  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    fz_frz = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    fz_op  = '{0, 1, 2, 3, 3, 3, 0, 0, 0};
    fz_ov  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    fz_out = '{0, 0, 6, 6, 6, 20, 42, 72, 0};

    rst_l = 1'b0; lsu_result = 32'd0;
    idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); tick();
    chk("rst_valid", {63'd0, ov3}, 64'd0);
    chk("rst_out", {32'd0, o3}, 64'd0);
    chk("rst_tag", {59'd0, t3}, 64'd0);
    chk("rst_busy", {61'd0, b2, b3, b5}, 64'd0);
    rst_l = 1'b1;
    tick();

    // single ops checked at each depth's own latency
    for (int i = 0; i < 12; i++) begin
      tg = 5'(i + 5);
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].s1, vecs[i].s2, vecs[i].lo, tg);
      for (int k = 1; k <= 6; k++) begin
        tick();
        if (k == 1) in_valid = 1'b0;
        chk_lat(vecs[i].nm, 2, k, ov2, o2, t2, vecs[i].req, tg);
        chk_lat(vecs[i].nm, 3, k, ov3, o3, t3, vecs[i].req, tg);
        chk_lat(vecs[i].nm, 5, k, ov5, o5, t5, vecs[i].req, tg);
      end
    end

    // MULHSU, MULHU, MUL back to back: in order on consecutive cycles
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd1);
        1:       drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd2);
        2:       drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd3);
        default: idle();
      endcase
      tick();
      if (k >= 2 && k <= 4) begin
        chk($sformatf("b2b_valid_%0d", k), {63'd0, ov3}, 64'd1);
        chk($sformatf("b2b_out_%0d", k), {32'd0, o3}, {32'd0, bb_req[k-2]});
        chk($sformatf("b2b_tag_%0d", k), {59'd0, t3}, 64'(k - 1));
      end else begin
        chk($sformatf("b2b_valid_%0d", k), {63'd0, ov3}, 64'd0);
      end
    end

    // four MULs with a two-cycle freeze; op 4 re-presented after the freeze
    for (int e = 0; e < 9; e++) begin
      drive(fz_iv[e] != 0, 32'(2 * (fz_op[e] + 1)), 32'(2 * fz_op[e] + 3),
            1'b0, 1'b0, 1'b1, 5'(fz_op[e] + 1));
      freeze = (fz_frz[e] != 0);
      tick();
      chk($sformatf("frz_valid_e%0d", e), {63'd0, ov3}, 64'(fz_ov[e]));
      if (fz_ov[e] != 0)
        chk($sformatf("frz_out_e%0d", e), {32'd0, o3}, {32'd0, fz_out[e]});
      if (fz_frz[e] != 0)
        chk($sformatf("frz_busy_e%0d", e), {63'd0, b3}, 64'd1);
    end
    idle();
    tick();

    byp_test("byp_rs1", 1'b1, 1'b0, 32'd0, 32'd6, 32'd7, 32'd42);
    byp_test("byp_rs2", 1'b0, 1'b1, 32'd5, 32'd0, 32'd9, 32'd45);

    // flush with an op presented on the flush cycle
    drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 5'd1);
    tick();
    drive(1'b1, 32'd4, 32'd4, 1'b0, 1'b0, 1'b1, 5'd2);
    tick();
    drive(1'b1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 5'd3);
    flush = 1'b1;
    tick();
    idle();
    chk("flush_valid", {62'd0, ov3, ov5}, 64'd0);
    chk("flush_busy", {61'd0, b2, b3, b5}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("flush_quiet_%0d", k), {61'd0, ov2, ov3, ov5}, 64'd0);
    end
    chk("flush_out_held", {32'd0, o3}, 64'd45);

    // flush wins over freeze
    drive(1'b1, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 5'd4);
    tick();
    idle(); freeze = 1'b1; flush = 1'b1;
    tick();
    idle();
    chk("frzflush_busy", {61'd0, b2, b3, b5}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("frzflush_quiet_%0d", k), {61'd0, ov2, ov3, ov5}, 64'd0);
    end

    // asynchronous reset mid-flight
    drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 5'd7);
    tick();
    idle();
    rst_l = 1'b0;
    #1;
    chk("arst_valid", {61'd0, ov2, ov3, ov5}, 64'd0);
    chk("arst_out3", {32'd0, o3}, 64'd0);
    chk("arst_out5", {32'd0, o5}, 64'd0);
    chk("arst_tag3", {59'd0, t3}, 64'd0);
    chk("arst_busy", {61'd0, b2, b3, b5}, 64'd0);
    tick();
    rst_l = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("arst_quiet_%0d", k), {61'd0, ov2, ov3, ov5}, 64'd0);
    end

    drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 5'd7);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) in_valid = 1'b0;
      chk_lat("post_rst", 2, k, ov2, o2, t2, 32'd12, 5'd7);
      chk_lat("post_rst", 3, k, ov3, o3, t3, 32'd12, 5'd7);
      chk_lat("post_rst", 5, k, ov5, o5, t5, 32'd12, 5'd7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exu_mul_pipe_gen.md
Name: exu_mul_pipe_gen

Overview:
- Parametrised pipelined integer multiplier for the EXU. It generalises the fixed 32-bit, 3-stage multiply unit to configurable operand width and pipeline depth.
- Adds features the fixed unit lacks: flush/kill, output valid, op tag pass-through and a busy indication.
- Executes RISC-V MUL/MULH/MULHSU/MULHU.
- Sits beside the ALU in the EXU. Results go to writeback, tagged for the scoreboard.

Parameters:
- XLEN, 32, operand and result width (16..64).
- STAGES, 3, issue-to-result latency in cycles (2..5). Must be ≥2; elaboration error otherwise.
- TAGW, 5, width of the op tag (destination register index).

Ports:
- clk  in  1  top-level clock
- rst_l  in  1  asynchronous active-low reset
- freeze  in  1  pipeline stall; holds every stage
- flush  in  1  kill all in-flight ops, including one presented this cycle
- in_valid  in  1  op issue strobe
- rs1_sign  in  1  treat a as signed
- rs2_sign  in  1  treat b as signed
- low  in  1  1 = return low half (MUL); 0 = return high half
- rs1_byp  in  1  replace a with lsu_result in stage 1
- rs2_byp  in  1  replace b with lsu_result in stage 1
- a  in  XLEN  operand A
- b  in  XLEN  operand B
- tag  in  TAGW  op tag
- lsu_result  in  XLEN  load data, sampled during stage 1 for bypass
- out_valid  out  1  result valid
- out  out  XLEN  result
- out_tag  out  TAGW  tag of the result
- busy  out  1  OR of all internal stage valids and out_valid

Behaviour:
- Reset (async assert, sync release): all stage valids = 0; out_valid = 0, out = 0, out_tag = 0, busy = 0. Data registers need not reset except out and out_tag.
- Latency: op accepted at edge N (in_valid & ~freeze & ~flush) gives out_valid = 1 with its result in the cycle after edge N+STAGES-1, absent freeze. With STAGES=3: accepted edge 0, output visible after edge 2.
- Throughput: one op per cycle; no backpressure other than freeze.
- Stage 1 register: captures a, b, sign bits, low, bypass flags, tag.
- Stage 1 logic:
  - Operand = lsu_result if its bypass flag is set, else the captured operand.
  - neg_x = sign_x & operand[XLEN-1].
  - Register {neg, operand} as (XLEN+1)-bit signed values.
- Stage 2: signed (XLEN+1)×(XLEN+1) product; keep bits [2*XLEN-1:0].
- Stages 3..STAGES-1: product/low/tag delay registers. With STAGES=2, stage 2 feeds the output register directly.
- Output: out = low ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN], registered.
- Data registers are enabled only when the incoming stage valid = 1 and ~freeze (clock-gate-equivalent enable).
- out and out_tag hold their last value while out_valid = 0.
- freeze = 1:
  - No stage advances; out_valid, out and out_tag hold.
  - in_valid is ignored; the issuer must re-present the op after the freeze.
- flush = 1:
  - Next cycle, all stage valids and out_valid = 0; an op issued in the same cycle is dropped.
  - flush overrides freeze.
  - Data registers are not required to clear.
- flush during freeze: ops are still killed.
- Reset mid-operation: in-flight ops are discarded; no out_valid after release until a new op completes.
- Operand corners:
  - Most-negative × most-negative, signed, fits in the 2*XLEN+2-bit product; no overflow handling.
  - MULHSU with a negative rs1 and a large unsigned rs2 must be exact.

Decomposition:
- swerv_types_pkg:
  - mul_pkt_gen_t {valid, rs1_sign, rs2_sign, low, rs1_byp, rs2_byp}, replacing the discrete control ports in the integration wrapper.
  - Localparam PROD_W = 2*XLEN+2.
- Sub-module exu_mul_dly_pipe: generic valid+data delay line parametrised by width and depth, with freeze/flush semantics. Used for the product/low/tag stages 3..STAGES-1.
- Built from rvdffe/rvdffs primitives.

Test Plan:
- XLEN=32, STAGES=3; MULH a=0x80000000, b=0x80000000, signed/signed → out=0x40000000, out_valid exactly 3 cycles after issue, out_tag echoes 5.
- a=b=0xFFFFFFFF: MULHSU → 0xFFFFFFFF; MULHU → 0xFFFFFFFE; MUL → 0x00000001 (low half). Issue the three ops back-to-back; they must return in order on 3 consecutive cycles.
- Four back-to-back MULs (2×3, 4×5, 6×7, 8×9), freeze high 2 cycles after the 2nd issue → outputs 6, 20, 42, 72 in order. The first result (6) appears at its normal time and holds through the freeze; no result is duplicated or lost.
- Issue MUL a=0 with rs1_byp=1, b=6; lsu_result=7 in stage 1 → out=42.
- Issue 3 ops, assert flush 1 cycle after the 3rd, with in_valid=1 on the flush cycle → no out_valid at all; busy=0 the next cycle.
- Assert rst_l low 1 cycle after issue → out_valid=0, out=0 immediately. Repeat with STAGES=2 and STAGES=5, checking latency equals STAGES.
